// File: rtl/input_conditioner.sv
// input_conditioner
//   Board-level front end between the raw pins and the game/display logic.
//   Generates a power-on reset pulse, synchronises and debounces N raw
//   button/switch levels, produces one-cycle rising-edge pulses and the
//   combined system reset.
//
// Ports
//   clock      system clock (65 MHz pixel clock)
//   reset      asynchronous active-low reset
//   noisy      raw asynchronous button/switch levels, N bits
//   clean      debounced levels, N bits
//   rise       one-cycle pulse when the matching clean bit goes 0->1, N bits
//   por_out    power-on reset, high for POR_CYCLES clocks after reset release
//   sys_reset  por_out | clean[RESET_CH]
module input_conditioner #(
   parameter int unsigned N          = 6,
   parameter int unsigned DELAY      = 650000,
   parameter int unsigned POR_CYCLES = 16,
   parameter int unsigned RESET_CH   = 0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] noisy,
   output logic [N-1:0] clean,
   output logic [N-1:0] rise,
   output logic         por_out,
   output logic         sys_reset
);

   localparam int unsigned CW     = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
   localparam int unsigned POR_TAP = POR_CYCLES - 1;
   localparam logic [CW-1:0] DELAY_COUNT = CW'(DELAY);

   logic [15:0]   por_sr;
   logic [N-1:0]  sync_a;
   logic [N-1:0]  sync_b;
   logic [N-1:0]  new_lvl;
   logic [N-1:0]  prev;
   logic [CW-1:0] count [N];

   // Power-on reset: preset to ones, zeros shift in from the bottom, so the
   // chosen tap falls exactly POR_CYCLES edges after release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         por_sr <= '1;
      end else begin
         por_sr <= {por_sr[14:0], 1'b0};
      end
   end

   assign por_out = por_sr[POR_TAP];

   // Two-flop synchroniser on every raw input.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= noisy;
         sync_b <= sync_a;
      end
   end

   // Debounce: a level is accepted once the synchronised input has matched
   // new_lvl for DELAY further cycles. During power-on reset the clean level
   // simply tracks the synchroniser so there is no step when POR ends.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         new_lvl <= '0;
         clean   <= '0;
         prev    <= '0;
         for (int i = 0; i < int'(N); i++) begin
            count[i] <= '0;
         end
      end else begin
         prev <= clean;
         for (int i = 0; i < int'(N); i++) begin
            if (por_out) begin
               new_lvl[i] <= sync_b[i];
               clean[i]   <= sync_b[i];
               count[i]   <= '0;
            end else if (sync_b[i] != new_lvl[i]) begin
               new_lvl[i] <= sync_b[i];
               count[i]   <= '0;
            end else if (count[i] == DELAY_COUNT) begin
               // Counter holds at DELAY; clean keeps reloading the same level.
               clean[i] <= new_lvl[i];
            end else begin
               count[i] <= count[i] + 1'b1;
            end
         end
      end
   end

   // Edge pulses are masked during POR so power-on levels never pulse.
   assign rise      = clean & ~prev & {N{~por_out}};
   assign sys_reset = por_out | clean[RESET_CH];

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//   Directed bench for input_conditioner with DELAY=8, POR_CYCLES=16.
//   A window-based reference model computes the expected outputs at each
//   clock edge; they are queued and compared after the DUT settles.
module tb_input_conditioner;

   localparam int N        = 6;
   localparam int DELAY    = 8;
   localparam int POR      = 16;
   localparam int RESET_CH = 0;
   localparam int HIST     = DELAY + 4;

   typedef struct packed {
      logic [N-1:0] clean;
      logic [N-1:0] rise;
      logic         por;
   } exp_t;

   logic         clock;
   logic         reset;
   logic [N-1:0] noisy;
   logic [N-1:0] clean;
   logic [N-1:0] rise;
   logic         por_out;
   logic         sys_reset;

   int checks = 0;
   int errors = 0;

   exp_t         sb [$];
   logic [N-1:0] hist [HIST];
   logic [N-1:0] m_clean;
   logic [N-1:0] m_prev;
   int           m_edges;
   int           rise_seen [N];
   int           por_cnt;
   int           lat;

   input_conditioner #(
      .N          (N),
      .DELAY      (DELAY),
      .POR_CYCLES (POR),
      .RESET_CH   (RESET_CH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .noisy     (noisy),
      .clean     (clean),
      .rise      (rise),
      .por_out   (por_out),
      .sys_reset (sys_reset)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < HIST; j++) hist[j] = '0;
      m_clean = '0;
      m_prev  = '0;
      m_edges = 0;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < N; i++) rise_seen[i] = 0;
      por_cnt = 0;
   endtask

   // Advance n clocks. At each edge the model derives the expected outputs
   // from the pin history: pins reach the debouncer two edges late, and a
   // level is accepted once it has been seen for DELAY+2 consecutive edges.
   task automatic step(input int n);
      for (int c = 0; c < n; c++) begin
         exp_t e;
         exp_t got;
         logic por_before;
         logic all1;
         logic all0;
         @(posedge clock);
         if (!reset) begin
            e.clean = '0;
            e.rise  = '0;
            e.por   = 1'b1;
         end else begin
            por_before = (m_edges < POR);
            for (int j = HIST - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = noisy;
            m_prev  = m_clean;
            if (por_before) begin
               m_clean = hist[2];
            end else begin
               for (int ch = 0; ch < N; ch++) begin
                  all1 = 1'b1;
                  all0 = 1'b1;
                  for (int j = 2; j < HIST; j++) begin
                     all1 = all1 & hist[j][ch];
                     all0 = all0 & ~hist[j][ch];
                  end
                  if (all1) m_clean[ch] = 1'b1;
                  else if (all0) m_clean[ch] = 1'b0;
               end
            end
            m_edges++;
            e.por   = (m_edges < POR);
            e.clean = m_clean;
            e.rise  = m_clean & ~m_prev & {N{~e.por}};
         end
         sb.push_back(e);
         #1;
         got = sb.pop_front();
         check("clean", 32'(clean), 32'(got.clean));
         check("rise", 32'(rise), 32'(got.rise));
         check("por_out", 32'(por_out), 32'(got.por));
         check("sys_reset", 32'(sys_reset), 32'(got.por | got.clean[RESET_CH]));
         for (int i = 0; i < N; i++) rise_seen[i] += int'(rise[i]);
         por_cnt += int'(por_out);
      end
   endtask

   initial begin
      reset = 1'b0;
      noisy = '0;
      model_reset();
      clear_counts();
      step(3);

      // Power-on: released mid-cycle, so por_out is high now and after the
      // first 15 edges, i.e. for 16 rising edges in total.
      reset = 1'b1;
      #1;
      check("por_at_release", 32'(por_out), 32'd1);
      clear_counts();
      step(20);
      check("por_len", 32'(por_cnt), 32'd15);
      check("por_end", 32'(por_out), 32'd0);

      // Held press on channel 1: DELAY+4 edges from the pin to clean.
      clear_counts();
      noisy[1] = 1'b1;
      lat = 0;
      while (clean[1] !== 1'b1 && lat < 40) begin
         step(1);
         lat++;
      end
      check("latency_ch1", 32'(lat), 32'd12);
      step(5);
      check("rise_cnt_ch1", 32'(rise_seen[1]), 32'd1);

      // Pulse shorter than DELAY on channel 2 is rejected.
      clear_counts();
      noisy[2] = 1'b1;
      step(5);
      noisy[2] = 1'b0;
      step(20);
      check("glitch_clean_ch2", 32'(clean[2]), 32'd0);
      check("glitch_rise_ch2", 32'(rise_seen[2]), 32'd0);

      // Bounce on channel 3 then hold high: exactly one accepted edge.
      clear_counts();
      for (int k = 0; k < 4; k++) begin
         noisy[3] = (k % 2 == 0);
         step(3);
      end
      noisy[3] = 1'b1;
      step(25);
      check("bounce_clean_ch3", 32'(clean[3]), 32'd1);
      check("bounce_rise_ch3", 32'(rise_seen[3]), 32'd1);

      // User reset button drives sys_reset once debounced.
      noisy[RESET_CH] = 1'b1;
      step(15);
      check("btn_sys_reset_on", 32'(sys_reset), 32'd1);
      check("btn_por_low", 32'(por_out), 32'd0);
      noisy[RESET_CH] = 1'b0;
      step(15);
      check("btn_sys_reset_off", 32'(sys_reset), 32'd0);

      // Two channels change together in opposite directions.
      noisy[5] = 1'b1;
      noisy[1] = 1'b0;
      step(15);
      check("indep_clean_ch5", 32'(clean[5]), 32'd1);
      check("indep_clean_ch1", 32'(clean[1]), 32'd0);

      // Reset mid-count takes effect without waiting for a clock edge.
      noisy[4] = 1'b1;
      step(5);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("async_clean", 32'(clean), 32'd0);
      check("async_rise", 32'(rise), 32'd0);
      check("async_por", 32'(por_out), 32'd1);
      check("async_sys_reset", 32'(sys_reset), 32'd1);
      step(2);
      reset = 1'b1;
      clear_counts();
      step(25);
      // Levels already high at power-on come out of POR without a pulse.
      check("por_level_ch4", 32'(clean[4]), 32'd1);
      check("por_level_ch5", 32'(clean[5]), 32'd1);
      check("por_norise_ch4", 32'(rise_seen[4]), 32'd0);
      check("por_norise_ch5", 32'(rise_seen[5]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end conditioning block for the board top level; sits between raw pins and all game/display logic.
- Generates a power-on reset pulse from a 16-stage shift register preset to all ones (SRL16-style).
- Debounces N raw inputs (buttons BTNC/U/D/L/R, SW[0]) into clean levels plus single-cycle rising-edge pulses.
- Produces the combined system reset (power-on OR debounced reset button).

Parameters:
- N, 6, number of debounced channels.
- DELAY, 650000, stable cycles required before a level is accepted (10 ms at 65 MHz).
- POR_CYCLES, 16, length of the power-on reset pulse in clocks (1..16).
- RESET_CH, 0, index of the channel used as the user reset button.

Ports:
- clock, input, 1, system clock (65 MHz pixel clock).
- reset, input, 1, asynchronous active-low reset.
- noisy, input, N, raw asynchronous button/switch levels.
- clean, output, N, debounced levels.
- rise, output, N, one-cycle pulse when the corresponding clean bit goes 0->1.
- por_out, output, 1, power-on reset, high for POR_CYCLES clocks after reset release.
- sys_reset, output, 1, por_out | clean[RESET_CH].

Behaviour:
- Clocking and reset:
  - All state is on the clock rising edge.
  - reset low asynchronously forces: POR shift register all ones (por_out=1); clean=0, rise=0, all counters=0, sync/"new" registers=0. sys_reset=1 therefore.
- Power-on reset:
  - 16-bit shift register shifts in 0 each clock after reset release.
  - por_out = tap POR_CYCLES-1, so it stays high exactly POR_CYCLES rising edges after release, then 0 until the next reset.
- Synchronizer:
  - Each noisy bit passes through a 2-flop synchronizer before debouncing.
  - This adds 2 cycles latency.
- Debounce, per channel i, while por_out=1:
  - new_i <= sync_i; clean_i <= sync_i; count_i <= 0.
  - Clean therefore tracks the input directly during power-on, with no glitch on exit.
- Debounce, per channel i, otherwise:
  - If sync_i != new_i: new_i <= sync_i, count_i <= 0.
  - Else if count_i == DELAY: clean_i <= new_i; count saturates, no wrap.
  - Else count_i <= count_i + 1.
- Latency: input held stable → clean changes DELAY+1 cycles after the first stable sample reaches new_i, i.e. about DELAY+4 clocks from the pin.
- Glitches: any toggle shorter than DELAY cycles never reaches clean; each toggle restarts the count from 0.
- Counter width: clog2(DELAY+1) bits.
- rise:
  - Registered: prev_i <= clean_i; rise_i = clean_i & ~prev_i.
  - High exactly one cycle per accepted 0->1 transition, never during por_out=1.
  - prev_i is loaded with clean_i while por_out=1, so a level already high at power-on produces no pulse.
- Channel independence: simultaneous changes on several channels are debounced independently.
- sys_reset: combinational OR of por_out and clean[RESET_CH].
- Mid-operation reset: asserting reset at any time aborts all counts, restarts POR, and clears outputs as above.

Test Plan:
- Release reset, noisy=0, POR_CYCLES=16 → por_out=1 for exactly 16 clocks then 0; sys_reset follows; clean=0, rise=0 throughout.
- DELAY=8: after POR, raise noisy[1] and hold → clean[1] rises 1 after ~12 clocks; rise[1] high for exactly 1 cycle.
- DELAY=8: 5-cycle pulse on noisy[2] → clean[2] stays 0, rise[2] never asserts.
- DELAY=8: bounce noisy[3] (1,0,1,0,1 every 3 cycles), then hold 1 → clean[3] rises only DELAY+1 cycles after the last edge reaches new; exactly one rise pulse.
- Hold noisy[RESET_CH]=1 → after debounce sys_reset=1 while por_out=0; release → sys_reset returns 0 after debounce.
- noisy[4]=1 before reset release → clean[4]=1 when POR ends with no rise pulse. Assert reset mid-count → clean=0, por_out=1 immediately (asynchronously).
